// File: rtl/mul16_if.sv
// Start/busy/done operand and result bundle for the sequential multiplier.
interface mul16_if #(
  parameter int WIDTH = 16
);
  logic               start;
  logic               is_signed;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;
  logic               overflow;

  modport master (
    output start, is_signed, multiplicand, multiplier,
    input  busy, done, product, overflow
  );
  modport slave (
    input  start, is_signed, multiplicand, multiplier,
    output busy, done, product, overflow
  );
endinterface

// File: rtl/mul16_seq.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, sign handled by
// multiplying magnitudes and negating the full-width result at the end.
module mul16_seq #(
  parameter int WIDTH = 16
) (
  input logic    clk,
  input logic    rst,
  mul16_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             r_state, w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH:0]     r_acc;
  logic [WIDTH:0]     r_mcand;
  logic [WIDTH-1:0]   r_mul;
  logic               r_neg;
  logic               r_signed;
  logic [2*WIDTH-1:0] r_product;
  logic               r_overflow;

  logic               w_accept, w_last;
  logic [WIDTH:0]     w_a_ext, w_b_ext, w_a_mag, w_b_mag;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH:0]   w_shift;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH:0]     w_hi;
  logic               w_ovf;

  assign w_accept = bus.start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_last   = (r_state == S_RUN) && (r_cnt == CNT_W'(WIDTH - 1));

  // Magnitudes need WIDTH+1 bits so that |-2^(WIDTH-1)| stays exact.
  assign w_a_ext = {bus.is_signed & bus.multiplicand[WIDTH-1], bus.multiplicand};
  assign w_b_ext = {bus.is_signed & bus.multiplier[WIDTH-1],   bus.multiplier};
  assign w_a_mag = w_a_ext[WIDTH] ? -w_a_ext : w_a_ext;
  assign w_b_mag = w_b_ext[WIDTH] ? -w_b_ext : w_b_ext;

  assign w_sum   = r_acc + (r_mul[0] ? r_mcand : '0);
  assign w_shift = {w_sum, r_mul} >> 1;
  assign w_prod  = r_neg ? -w_shift[2*WIDTH-1:0] : w_shift[2*WIDTH-1:0];

  assign w_hi  = w_prod[2*WIDTH-1:WIDTH-1];
  assign w_ovf = r_signed ? !((&w_hi) || !(|w_hi)) : (|w_prod[2*WIDTH-1:WIDTH]);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_RUN;
      S_RUN:   if (w_last)   w_next = S_DONE;
      S_DONE:  w_next = w_accept ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_acc      <= '0;
      r_mcand    <= '0;
      r_mul      <= '0;
      r_neg      <= 1'b0;
      r_signed   <= 1'b0;
      r_product  <= '0;
      r_overflow <= 1'b0;
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= w_a_mag;
      r_mul    <= w_b_mag[WIDTH-1:0];
      r_neg    <= w_a_ext[WIDTH] ^ w_b_ext[WIDTH];
      r_signed <= bus.is_signed;
    end else if (r_state == S_RUN) begin
      r_cnt <= r_cnt + 1'b1;
      r_acc <= w_shift[2*WIDTH:WIDTH];
      r_mul <= w_shift[WIDTH-1:0];
      // Result registers change only here, so they hold through IDLE and RUN.
      if (w_last) begin
        r_product  <= w_prod;
        r_overflow <= w_ovf;
      end
    end
  end

  assign bus.busy     = (r_state == S_RUN);
  assign bus.done     = (r_state == S_DONE);
  assign bus.product  = r_product;
  assign bus.overflow = r_overflow;
endmodule
